ysyx_22050019_axi_sram_slave: RTL and testbench

AXI4-Lite style responder that terminates the LSU's independent read and write channels on an on-chip, byte-strobed 64-bit SRAM. Each channel has a programmable response latency to emulate memory delay. The block sits on the data side of the core in place of a DPI memory model, so the LSU handshake state machines are exercised end-to-end in simulation.

---
 rtl/ysyx_22050019_axi_pkg.sv | 35 +++
 rtl/ysyx_22050019_sram_bank.sv | 28 ++
 rtl/ysyx_22050019_axi_sram_slave.sv | 163 ++++++++++++++++
 tb/tb_ysyx_22050019_axi_sram_slave.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared definitions for the LSU-side AXI4-Lite SRAM responder.
package ysyx_22050019_axi_pkg;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_WAIT,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_t;

  // Offset form avoids overflow of base + 8*depth near the top of the address space.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] depth);
    logic [63:0] off;
    off = addr - base;
    return (addr >= base) && (off < (depth << 3));
  endfunction

  // Word index; addr[2:0] is dropped by the shift.
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                input logic [63:0] base);
    return (addr - base) >> 3;
  endfunction

endpackage

// File: rtl/ysyx_22050019_sram_bank.sv
// MEM_DEPTH x 64 storage with a byte-strobed write port and a registered read port.
module ysyx_22050019_sram_bank #(
  parameter int unsigned MEM_DEPTH = 1024,
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] w_idx,
  input  logic [63:0]      w_data,
  input  logic [7:0]       w_strb,
  input  logic             re,
  input  logic [IDX_W-1:0] r_idx,
  output logic [63:0]      r_data
);

  logic [63:0] mem [MEM_DEPTH];

  // Write and read share one edge; the read sees the pre-write word on a conflict.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (w_strb[b]) mem[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
    if (re) r_data <= mem[r_idx];
  end

endmodule

// File: rtl/ysyx_22050019_axi_sram_slave.sv
// AXI4-Lite responder terminating independent read/write channels on an on-chip SRAM.
module ysyx_22050019_axi_sram_slave
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter logic [63:0] BASE_ADDR      = 64'h8000_0000,
  parameter int unsigned MEM_DEPTH      = 1024,
  parameter int unsigned RD_LATENCY     = 2,
  parameter int unsigned WR_LATENCY     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axi_aw_valid,
  output logic                        s_axi_aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_aw_addr,
  input  logic                        s_axi_w_valid,
  output logic                        s_axi_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_w_strb,
  output logic                        s_axi_b_valid,
  input  logic                        s_axi_b_ready,
  output logic [1:0]                  s_axi_b_resp,
  input  logic                        s_axi_ar_valid,
  output logic                        s_axi_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_ar_addr,
  output logic                        s_axi_r_valid,
  input  logic                        s_axi_r_ready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_r_data,
  output logic [1:0]                  s_axi_r_resp
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned WR_CW = $clog2(((WR_LATENCY > 0) ? WR_LATENCY : 1) + 1);
  localparam int unsigned RD_CW = $clog2(((RD_LATENCY > 0) ? RD_LATENCY : 1) + 1);

  w_state_t         w_state;
  r_state_t         r_state;
  logic             live;
  logic [63:0]      aw_addr_q;
  logic [63:0]      ar_addr_q;
  logic [1:0]       b_resp_q;
  logic [1:0]       r_resp_q;
  logic [WR_CW-1:0] wr_cnt;
  logic [RD_CW-1:0] rd_cnt;

  logic             aw_hs, w_hs, ar_hs;
  logic             aw_ok, rd_ok;
  logic [63:0]      rd_addr;
  logic             bank_we, bank_re;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic [63:0]      bank_rdata;

  // Handshakes are decoded from registered state; live keeps every output low while in reset.
  assign s_axi_aw_ready = live && (w_state == W_IDLE);
  assign s_axi_w_ready  = live && (w_state == W_DATA);
  assign s_axi_b_valid  = live && (w_state == W_RESP);
  assign s_axi_b_resp   = b_resp_q;
  assign s_axi_ar_ready = live && (r_state == R_IDLE);
  assign s_axi_r_valid  = live && (r_state == R_DATA);
  assign s_axi_r_resp   = r_resp_q;
  assign s_axi_r_data   = (s_axi_r_valid && (r_resp_q == AXI_OKAY)) ? bank_rdata : '0;

  assign aw_hs = s_axi_aw_valid && s_axi_aw_ready;
  assign w_hs  = s_axi_w_valid && s_axi_w_ready;
  assign ar_hs = s_axi_ar_valid && s_axi_ar_ready;

  // With zero read latency the SRAM is read on the AR edge itself, straight from the bus.
  assign rd_addr = (RD_LATENCY == 0) ? s_axi_ar_addr : ar_addr_q;
  assign aw_ok   = addr_in_range(aw_addr_q, BASE_ADDR, 64'(MEM_DEPTH));
  assign rd_ok   = addr_in_range(rd_addr, BASE_ADDR, 64'(MEM_DEPTH));
  assign w_idx   = IDX_W'(addr_to_index(aw_addr_q, BASE_ADDR));
  assign r_idx   = IDX_W'(addr_to_index(rd_addr, BASE_ADDR));

  assign bank_we = w_hs && aw_ok && !rst;
  assign bank_re = rd_ok && ((RD_LATENCY == 0) ? ar_hs
                                               : ((r_state == R_WAIT) && (rd_cnt <= RD_CW'(1))));

  ysyx_22050019_sram_bank #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .w_idx (w_idx),
    .w_data(s_axi_w_data),
    .w_strb(s_axi_w_strb),
    .re    (bank_re),
    .r_idx (r_idx),
    .r_data(bank_rdata)
  );

  // Output-enable flag: low on every reset edge, high from the first edge after release.
  always_ff @(posedge clk) begin
    live <= !rst;
  end

  // Write channel: address, data commit, latency wait, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      wr_cnt    <= '0;
      aw_addr_q <= '0;
      b_resp_q  <= AXI_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          aw_addr_q <= s_axi_aw_addr;
          w_state   <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          b_resp_q <= aw_ok ? AXI_OKAY : AXI_SLVERR;
          if (WR_LATENCY == 0) begin
            w_state <= W_RESP;
          end else begin
            wr_cnt  <= WR_CW'(WR_LATENCY);
            w_state <= W_WAIT;
          end
        end
        W_WAIT: if (wr_cnt <= WR_CW'(1)) begin
          wr_cnt  <= '0;
          w_state <= W_RESP;
        end else begin
          wr_cnt <= wr_cnt - WR_CW'(1);
        end
        W_RESP: if (s_axi_b_ready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: address, latency wait with data capture on exit, data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      rd_cnt    <= '0;
      ar_addr_q <= '0;
      r_resp_q  <= AXI_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          ar_addr_q <= s_axi_ar_addr;
          if (RD_LATENCY == 0) begin
            r_resp_q <= rd_ok ? AXI_OKAY : AXI_SLVERR;
            r_state  <= R_DATA;
          end else begin
            rd_cnt  <= RD_CW'(RD_LATENCY);
            r_state <= R_WAIT;
          end
        end
        R_WAIT: if (rd_cnt <= RD_CW'(1)) begin
          rd_cnt   <= '0;
          r_resp_q <= rd_ok ? AXI_OKAY : AXI_SLVERR;
          r_state  <= R_DATA;
        end else begin
          rd_cnt <= rd_cnt - RD_CW'(1);
        end
        R_DATA: if (s_axi_r_ready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_axi_sram_slave.sv
// Self-checking bench for ysyx_22050019_axi_sram_slave against a word-array reference model.
module tb_ysyx_22050019_axi_sram_slave;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned RDL   = 2;
  localparam int unsigned WRL   = 2;
  localparam int          BOUND = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axi_aw_valid, s_axi_aw_ready;
  logic [63:0] s_axi_aw_addr;
  logic        s_axi_w_valid, s_axi_w_ready;
  logic [63:0] s_axi_w_data;
  logic [7:0]  s_axi_w_strb;
  logic        s_axi_b_valid, s_axi_b_ready;
  logic [1:0]  s_axi_b_resp;
  logic        s_axi_ar_valid, s_axi_ar_ready;
  logic [63:0] s_axi_ar_addr;
  logic        s_axi_r_valid, s_axi_r_ready;
  logic [63:0] s_axi_r_data;
  logic [1:0]  s_axi_r_resp;

  int checks   = 0;
  int failures = 0;

  logic [63:0] model [DEPTH];

  always #5 clk = ~clk;

  ysyx_22050019_axi_sram_slave #(
    .AXI_DATA_WIDTH(64),
    .AXI_ADDR_WIDTH(64),
    .BASE_ADDR     (BASE),
    .MEM_DEPTH     (DEPTH),
    .RD_LATENCY    (RDL),
    .WR_LATENCY    (WRL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_aw_valid(s_axi_aw_valid),
    .s_axi_aw_ready(s_axi_aw_ready),
    .s_axi_aw_addr (s_axi_aw_addr),
    .s_axi_w_valid (s_axi_w_valid),
    .s_axi_w_ready (s_axi_w_ready),
    .s_axi_w_data  (s_axi_w_data),
    .s_axi_w_strb  (s_axi_w_strb),
    .s_axi_b_valid (s_axi_b_valid),
    .s_axi_b_ready (s_axi_b_ready),
    .s_axi_b_resp  (s_axi_b_resp),
    .s_axi_ar_valid(s_axi_ar_valid),
    .s_axi_ar_ready(s_axi_ar_ready),
    .s_axi_ar_addr (s_axi_ar_addr),
    .s_axi_r_valid (s_axi_r_valid),
    .s_axi_r_ready (s_axi_r_ready),
    .s_axi_r_data  (s_axi_r_data),
    .s_axi_r_resp  (s_axi_r_resp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic timed_out(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * DEPTH));
  endfunction

  function automatic logic [1:0] exp_resp(input logic [63:0] a);
    return in_rng(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    int unsigned idx;
    if (in_rng(a)) begin
      idx = int'((a - BASE) / 8);
      for (int b = 0; b < 8; b++)
        if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  function automatic logic [63:0] model_read(input logic [63:0] a);
    if (!in_rng(a)) return 64'd0;
    return model[int'((a - BASE) / 8)];
  endfunction

  // Full write transaction; lat is the edge (counted from the W handshake edge as 0) at which b_valid is sampled.
  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          output logic [1:0] resp, output int lat);
    int n;
    s_axi_aw_valid = 1'b1;
    s_axi_aw_addr  = a;
    n = 0;
    while (!s_axi_aw_ready && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) timed_out("aw_ready");
    tick();
    s_axi_aw_valid = 1'b0;
    s_axi_w_valid  = 1'b1;
    s_axi_w_data   = d;
    s_axi_w_strb   = s;
    n = 0;
    while (!s_axi_w_ready && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) timed_out("w_ready");
    tick();
    s_axi_w_valid = 1'b0;
    lat = 1;
    while (!s_axi_b_valid && lat < BOUND) begin tick(); lat++; end
    if (lat >= BOUND) timed_out("b_valid");
    resp = s_axi_b_resp;
    s_axi_b_ready = 1'b1;
    tick();
    s_axi_b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] a, output logic [63:0] d,
                         output logic [1:0] resp, output int lat);
    int n;
    s_axi_ar_valid = 1'b1;
    s_axi_ar_addr  = a;
    n = 0;
    while (!s_axi_ar_ready && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) timed_out("ar_ready");
    tick();
    s_axi_ar_valid = 1'b0;
    lat = 1;
    while (!s_axi_r_valid && lat < BOUND) begin tick(); lat++; end
    if (lat >= BOUND) timed_out("r_valid");
    d    = s_axi_r_data;
    resp = s_axi_r_resp;
    s_axi_r_ready = 1'b1;
    tick();
    s_axi_r_ready = 1'b0;
  endtask

  task automatic write_check(input string tag, input logic [63:0] a, input logic [63:0] d,
                             input logic [7:0] s);
    logic [1:0] resp;
    int lat;
    do_write(a, d, s, resp, lat);
    model_write(a, d, s);
    check({tag, "_bresp"}, 64'(resp), 64'(exp_resp(a)));
    check({tag, "_blat"}, 64'(lat), 64'(WRL + 1));
  endtask

  task automatic read_check(input string tag, input logic [63:0] a);
    logic [63:0] d;
    logic [1:0]  resp;
    int lat;
    do_read(a, d, resp, lat);
    check({tag, "_rresp"}, 64'(resp), 64'(exp_resp(a)));
    check({tag, "_rdata"}, d, model_read(a));
    check({tag, "_rlat"}, 64'(lat), 64'(RDL + 1));
  endtask

  initial begin
    logic [63:0] a, d, old_word;
    logic [7:0]  s;
    int n;
    int unsigned k;

    rst = 1'b1;
    s_axi_aw_valid = 1'b0; s_axi_aw_addr = '0;
    s_axi_w_valid  = 1'b0; s_axi_w_data  = '0; s_axi_w_strb = '0;
    s_axi_b_ready  = 1'b0;
    s_axi_ar_valid = 1'b0; s_axi_ar_addr = '0;
    s_axi_r_ready  = 1'b0;
    repeat (3) tick();

    // reset state
    check("reset_ctrl", {s_axi_aw_ready, s_axi_w_ready, s_axi_b_valid, s_axi_ar_ready,
                         s_axi_r_valid, s_axi_b_resp, s_axi_r_resp}, '0);
    check("reset_rdata", s_axi_r_data, '0);
    rst = 1'b0;
    tick();
    check("post_reset_ready", {s_axi_aw_ready, s_axi_ar_ready, s_axi_w_ready}, 3'b110);

    // prefill words 0..15 and the last word so every in-range target is defined
    for (int i = 0; i < 16; i++)
      write_check("prefill", BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
    write_check("prefill_last", BASE + 64'(8 * (DEPTH - 1)), {$urandom, $urandom}, 8'hFF);

    // write then read
    write_check("wr_basic", 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    read_check("rd_basic", 64'h8000_0010);
    check("rd_basic_value", model_read(64'h8000_0010), 64'h1122_3344_5566_7788);

    // partial strobe
    write_check("strb_full", 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    write_check("strb_low", 64'h8000_0020, 64'h0, 8'h0F);
    read_check("strb_rd", 64'h8000_0020);

    // out of range below base, at the top boundary, and the last in-range word with low bits set
    write_check("oor_lo", 64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    read_check("oor_lo", 64'h7FFF_FFF8);
    read_check("word0_intact", BASE);
    write_check("oor_hi", BASE + 64'(8 * DEPTH), 64'hCAFE_F00D_CAFE_F00D, 8'hFF);
    read_check("oor_hi", BASE + 64'(8 * DEPTH));
    read_check("last_word", BASE + 64'(8 * (DEPTH - 1)) + 64'd5);
    read_check("word0_intact2", BASE + 64'd3);

    // backpressure on both channels simultaneously
    s_axi_aw_valid = 1'b1; s_axi_aw_addr = BASE + 64'd24;
    s_axi_ar_valid = 1'b1; s_axi_ar_addr = BASE + 64'd40;
    tick();
    s_axi_aw_valid = 1'b0; s_axi_ar_valid = 1'b0;
    s_axi_w_valid = 1'b1; s_axi_w_data = 64'h0102_0304_0506_0708; s_axi_w_strb = 8'hFF;
    tick();
    s_axi_w_valid = 1'b0;
    model_write(BASE + 64'd24, 64'h0102_0304_0506_0708, 8'hFF);
    n = 0;
    while (!(s_axi_b_valid && s_axi_r_valid) && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) timed_out("bp_valids");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_ctrl", {s_axi_b_valid, s_axi_r_valid, s_axi_aw_ready, s_axi_ar_ready,
                             s_axi_b_resp, s_axi_r_resp}, 8'b1100_0000);
      check("bp_hold_rdata", s_axi_r_data, model_read(BASE + 64'd40));
      tick();
    end
    s_axi_b_ready = 1'b1; s_axi_r_ready = 1'b1;
    tick();
    s_axi_b_ready = 1'b0; s_axi_r_ready = 1'b0;
    check("bp_release", {s_axi_b_valid, s_axi_r_valid, s_axi_aw_ready, s_axi_ar_ready}, 4'b0011);
    read_check("bp_written", BASE + 64'd24);

    // same-word conflict: W handshake lands on the read-capture edge
    a = BASE + 64'd56;
    old_word = model_read(a);
    d = ~old_word ^ 64'h5A5A_0000_0000_A5A5;
    s_axi_aw_valid = 1'b1; s_axi_aw_addr = a;
    s_axi_ar_valid = 1'b1; s_axi_ar_addr = a;
    tick();
    s_axi_aw_valid = 1'b0; s_axi_ar_valid = 1'b0;
    repeat (RDL - 1) tick();
    s_axi_w_valid = 1'b1; s_axi_w_data = d; s_axi_w_strb = 8'hFF;
    tick();
    s_axi_w_valid = 1'b0;
    check("conflict_rvalid", 64'(s_axi_r_valid), 64'd1);
    check("conflict_old", s_axi_r_data, old_word);
    s_axi_r_ready = 1'b1;
    tick();
    s_axi_r_ready = 1'b0;
    n = 0;
    while (!s_axi_b_valid && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) timed_out("conflict_b");
    s_axi_b_ready = 1'b1;
    tick();
    s_axi_b_ready = 1'b0;
    model_write(a, d, 8'hFF);
    read_check("conflict_new", a);

    // reset while the read is waiting
    s_axi_ar_valid = 1'b1; s_axi_ar_addr = BASE + 64'd16;
    tick();
    s_axi_ar_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midrst_outputs", {s_axi_r_valid, s_axi_ar_ready, s_axi_aw_ready, s_axi_b_valid}, '0);
    end
    rst = 1'b0;
    tick();
    check("midrst_release", {s_axi_ar_ready, s_axi_r_valid}, 2'b10);
    for (int i = 0; i < RDL + 2; i++) begin
      tick();
      check("midrst_no_rvalid", 64'(s_axi_r_valid), 64'd0);
    end
    read_check("midrst_survive", BASE + 64'd16);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 16);
      if (k == 16) k = DEPTH - 1;
      a = BASE + 64'(8 * k) + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)
        a = ($urandom_range(0, 1) == 1) ? BASE - 64'(8 * $urandom_range(1, 4))
                                        : BASE + 64'(8 * (DEPTH + $urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        s = 8'($urandom);
        write_check("rand_wr", a, d, s);
      end else begin
        read_check("rand_rd", a);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
